// File: rtl/tarea1_arb_pkg.sv
// Shared types and defaults for the two-master on-chip memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tarea1_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // Index of a master port (0 or 1).
    typedef logic owner_t;

    // One tag-pipeline stage: a read is in flight and which master gets its data.
    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

endpackage

// File: rtl/tarea1_onchip_mem_arbiter_if.sv
// Avalon-MM style master port bundle: command from the master, waitrequest and read response back.
// Latency: n/a (wiring only).
// Backpressure: waitrequest stalls the master, which must hold its command stable while stalled.
interface tarea1_onchip_mem_arbiter_if
    import tarea1_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/tarea1_rr_arb2.sv
// Two-way round-robin grant with a registered last-grant pointer.
// Latency: grant is combinational, same cycle as the request.
// Backpressure: the loser of a contention is simply not granted; it wins the next contention.
module tarea1_rr_arb2
    import tarea1_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_any,
    output owner_t     winner
);

    owner_t last_grant;

    // Pick the winner: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

    assign grant_any = |req;
    assign grant     = grant_any ? (winner ? 2'b10 : 2'b01) : 2'b00;

    // Remember the last winner; reset to 1 so master 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (grant_any) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/tarea1_onchip_mem_arbiter.sv
// Shares one on-chip memory port between two masters with round-robin arbitration.
// Latency: command reaches memory in the grant cycle; read data returns READ_LATENCY cycles later.
// Backpressure: the losing master sees waitrequest; one access per cycle with no bubbles.
module tarea1_onchip_mem_arbiter
    import tarea1_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1
)(
    input  logic                         clk,
    input  logic                         reset,
    tarea1_onchip_mem_arbiter_if.slave   m0,
    tarea1_onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W/8-1:0]          mem_byteenable,
    output logic                         mem_chipselect,
    output logic                         mem_write,
    output logic [DATA_W-1:0]            mem_writedata,
    output logic                         mem_clken,
    input  logic [DATA_W-1:0]            mem_readdata
);

    logic [1:0] req;
    logic [1:0] grant;
    logic       grant_any;
    owner_t     winner;
    logic       win_write;
    tag_t       tag_q [READ_LATENCY];
    tag_t       tag_last;

    // A write with read also high counts as a write; either one is a request.
    assign req = {m1.read | m1.write, m0.read | m0.write};

    tarea1_rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .grant_any (grant_any),
        .winner    (winner)
    );

    // Steer the winner's command to memory; with no grant the m0 fields pass through as don't-care.
    always_comb begin
        mem_address    = m0.address;
        mem_byteenable = m0.byteenable;
        mem_writedata  = m0.writedata;
        win_write      = m0.write;
        if (grant_any && winner == 1'b1) begin
            mem_address    = m1.address;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
            win_write      = m1.write;
        end
    end

    // Reset blocks any access from reaching memory and stalls both masters.
    assign mem_chipselect = grant_any & ~reset;
    assign mem_write      = grant_any & win_write & ~reset;
    assign mem_clken      = 1'b1;

    assign m0.waitrequest = reset | (req[0] & ~grant[0]);
    assign m1.waitrequest = reset | (req[1] & ~grant[1]);

    // Track each granted read through the memory latency so its data is routed to the right master.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: grant_any & ~win_write, owner: winner};
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_last = tag_q[READ_LATENCY-1];

    assign m0.readdatavalid = tag_last.valid & (tag_last.owner == 1'b0);
    assign m1.readdatavalid = tag_last.valid & (tag_last.owner == 1'b1);
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_tarea1_onchip_mem_arbiter.sv
// Bench for the two-master arbiter: one instance at READ_LATENCY=1, one at 2, driven identically.
// Latency: n/a (testbench).
// Backpressure: stimulated masters hold their command while waitrequest is expected.
module tb_tarea1_onchip_mem_arbiter;
    import tarea1_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tarea1_onchip_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) a0 (), a1 (), b0 (), b1 ();

    logic [9:0]  a_addr, b_addr;
    logic [3:0]  a_be, b_be;
    logic        a_cs, a_we, a_clken, b_cs, b_we, b_clken;
    logic [31:0] a_wdat, b_wdat, a_rdata, b_rdata;

    tarea1_onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .m0(a0), .m1(a1),
        .mem_address(a_addr), .mem_byteenable(a_be), .mem_chipselect(a_cs), .mem_write(a_we),
        .mem_writedata(a_wdat), .mem_clken(a_clken), .mem_readdata(a_rdata)
    );

    tarea1_onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .m0(b0), .m1(b1),
        .mem_address(b_addr), .mem_byteenable(b_be), .mem_chipselect(b_cs), .mem_write(b_we),
        .mem_writedata(b_wdat), .mem_clken(b_clken), .mem_readdata(b_rdata)
    );

    // Environment memories behind each arbiter (1- and 2-cycle read paths).
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] rq_a, rq_b, rq_b2;

    always @(posedge clk) begin
        if (a_cs && a_we)
            for (int i = 0; i < 4; i++) if (a_be[i]) mem_a[a_addr][8*i +: 8] <= a_wdat[8*i +: 8];
        rq_a <= mem_a[a_addr];
        if (b_cs && b_we)
            for (int i = 0; i < 4; i++) if (b_be[i]) mem_b[b_addr][8*i +: 8] <= b_wdat[8*i +: 8];
        rq_b  <= mem_b[b_addr];
        rq_b2 <= rq_b;
    end
    assign a_rdata = rq_a;
    assign b_rdata = rq_b2;

    // Staged stimulus per master.
    logic        s_rst;
    logic        s_rd [2];
    logic        s_wr [2];
    logic [9:0]  s_addr [2];
    logic [3:0]  s_be [2];
    logic [31:0] s_wdat [2];

    // Reference model: arbitration rule, a word memory and a per-cycle log of granted reads.
    logic        m_last;
    logic [31:0] m_mem [0:1023];
    bit          g_rd [4096];
    bit          g_own [4096];
    logic [31:0] g_dat [4096];
    bit          rst_at [4096];
    int          cyc;
    logic        e_wait [2];

    // Observations captured in the sample window of the latest cycle.
    logic [233:0] obs_all, exp_all;
    logic         o_w [2];
    logic         o_cs;
    logic [9:0]   o_adr;
    logic         o_rv_a [2];
    logic         o_rv_b [2];
    logic [31:0]  o_rd_a, o_rd_b;

    int total, bad;

    task automatic set_idle(input int n);
        s_rd[n] = 1'b0; s_wr[n] = 1'b0; s_addr[n] = 10'h0; s_be[n] = 4'h0; s_wdat[n] = 32'h0;
    endtask

    task automatic set_cmd(input int n, input logic rd, input logic wr, input logic [9:0] ad,
                           input logic [3:0] be, input logic [31:0] wd);
        s_rd[n] = rd; s_wr[n] = wr; s_addr[n] = ad; s_be[n] = be; s_wdat[n] = wd;
    endtask

    task automatic rand_cmd(input int n, input bit force_req);
        int r;
        r = force_req ? $urandom_range(1, 3) : $urandom_range(0, 3);
        s_rd[n]   = (r == 1 || r == 3);
        s_wr[n]   = (r >= 2);
        s_addr[n] = 10'($urandom_range(0, 15));
        s_be[n]   = 4'($urandom_range(0, 15));
        s_wdat[n] = $urandom;
    endtask

    // One clock cycle: drive after the edge, sample mid-cycle, advance the model, wait for the edge.
    task automatic step();
        logic        r0, r1, any, win;
        logic [50:0] ec, oca, ocb;
        logic [65:0] er [2];
        logic [65:0] ora, orb;
        #1;
        reset = s_rst;
        a0.read = s_rd[0]; a0.write = s_wr[0]; a0.address = s_addr[0]; a0.byteenable = s_be[0]; a0.writedata = s_wdat[0];
        a1.read = s_rd[1]; a1.write = s_wr[1]; a1.address = s_addr[1]; a1.byteenable = s_be[1]; a1.writedata = s_wdat[1];
        b0.read = s_rd[0]; b0.write = s_wr[0]; b0.address = s_addr[0]; b0.byteenable = s_be[0]; b0.writedata = s_wdat[0];
        b1.read = s_rd[1]; b1.write = s_wr[1]; b1.address = s_addr[1]; b1.byteenable = s_be[1]; b1.writedata = s_wdat[1];
        #2;
        if (s_rst) m_last = 1'b1;
        rst_at[cyc] = s_rst;
        r0  = s_rd[0] | s_wr[0];
        r1  = s_rd[1] | s_wr[1];
        any = r0 | r1;
        win = (r0 && r1) ? ~m_last : r1;
        e_wait[0] = s_rst | (r0 & (win != 1'b0));
        e_wait[1] = s_rst | (r1 & (win != 1'b1));
        ec = {e_wait[0], e_wait[1], any & ~s_rst, any & s_wr[win] & ~s_rst, 1'b1,
              any ? s_addr[win] : s_addr[0], any ? s_be[win] : s_be[0], any ? s_wdat[win] : s_wdat[0]};
        oca = {a0.waitrequest, a1.waitrequest, a_cs, a_we, a_clken, a_addr, a_be, a_wdat};
        ocb = {b0.waitrequest, b1.waitrequest, b_cs, b_we, b_clken, b_addr, b_be, b_wdat};
        // A read granted in cycle g returns in cycle g+k unless reset was seen in between.
        for (int k = 1; k <= 2; k++) begin
            int g;
            bit v;
            g = cyc - k;
            v = 1'b0;
            if (g >= 0) begin
                v = g_rd[g];
                for (int j = g + 1; j <= cyc; j++) if (rst_at[j]) v = 1'b0;
            end
            er[k-1] = {v && !g_own[g < 0 ? 0 : g], v && g_own[g < 0 ? 0 : g],
                       (v && !g_own[g < 0 ? 0 : g]) ? g_dat[g < 0 ? 0 : g] : 32'h0,
                       (v &&  g_own[g < 0 ? 0 : g]) ? g_dat[g < 0 ? 0 : g] : 32'h0};
        end
        ora = {a0.readdatavalid, a1.readdatavalid, er[0][65] ? a0.readdata : 32'h0, er[0][64] ? a1.readdata : 32'h0};
        orb = {b0.readdatavalid, b1.readdatavalid, er[1][65] ? b0.readdata : 32'h0, er[1][64] ? b1.readdata : 32'h0};
        obs_all = {oca, ocb, ora, orb};
        exp_all = {ec, ec, er[0], er[1]};
        o_w[0] = a0.waitrequest; o_w[1] = a1.waitrequest; o_cs = a_cs; o_adr = a_addr;
        o_rv_a[0] = a0.readdatavalid; o_rv_a[1] = a1.readdatavalid; o_rd_a = a_rdata;
        o_rv_b[0] = b0.readdatavalid; o_rv_b[1] = b1.readdatavalid; o_rd_b = b_rdata;
        // Advance the model.
        g_rd[cyc]  = any && !s_wr[win] && !s_rst;
        g_own[cyc] = win;
        g_dat[cyc] = m_mem[s_addr[win]];
        if (any && s_wr[win] && !s_rst)
            for (int i = 0; i < 4; i++) if (s_be[win][i]) m_mem[s_addr[win]][8*i +: 8] = s_wdat[win][8*i +: 8];
        if (!s_rst && any) m_last = win;
        cyc++;
        @(posedge clk);
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_cmd(0, 1'b0); rand_cmd(1, 1'b0);
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL reset_state cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
        end
        s_rst = 1'b0; set_idle(0); set_idle(1);
    endtask

    task automatic test_single_read();
        set_cmd(1, 1'b0, 1'b1, 10'h005, 4'hF, 32'hCAFEF00D); set_idle(0);
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL single_read cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
            if (i == 1) begin
                total++;
                if (o_w[0] !== 1'b0 || o_cs !== 1'b1 || o_adr !== 10'h005) begin
                    bad++; $display("FAIL single_read_cmd got w0=%b cs=%b adr=%h want w0=0 cs=1 adr=005", o_w[0], o_cs, o_adr);
                end
            end
            if (i == 2) begin
                total++;
                if (o_rv_a[0] !== 1'b1 || o_rv_a[1] !== 1'b0 || o_rd_a !== 32'hCAFEF00D) begin
                    bad++; $display("FAIL single_read_rsp got v0=%b v1=%b d=%h want 1 0 cafef00d", o_rv_a[0], o_rv_a[1], o_rd_a);
                end
            end
            set_idle(1);
            if (i == 0) set_cmd(0, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0); else set_idle(0);
        end
    endtask

    task automatic test_contention();
        s_rst = 1'b1; step(); s_rst = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 10'h006, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL contention cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
            if (i == 0) begin
                total++;
                if (o_w[0] !== 1'b0 || o_w[1] !== 1'b1) begin
                    bad++; $display("FAIL contention_first got w0=%b w1=%b want 0 1", o_w[0], o_w[1]);
                end
                set_idle(0);
            end
            if (i == 1) begin
                total++;
                if (o_w[1] !== 1'b0 || o_adr !== 10'h006 || o_rv_a[0] !== 1'b1) begin
                    bad++; $display("FAIL contention_second got w1=%b adr=%h v0=%b want 0 006 1", o_w[1], o_adr, o_rv_a[0]);
                end
                set_idle(1);
            end
            if (i == 2) begin
                total++;
                if (o_rv_a[1] !== 1'b1 || o_rv_a[0] !== 1'b0) begin
                    bad++; $display("FAIL contention_m1_valid got v0=%b v1=%b want 0 1", o_rv_a[0], o_rv_a[1]);
                end
            end
        end
    endtask

    task automatic test_sustained();
        int cnt [2];
        int wc [2];
        int mx;
        cnt[0] = 0; cnt[1] = 0; wc[0] = 0; wc[1] = 0; mx = 0;
        s_rst = 1'b1; set_idle(0); set_idle(1); step(); s_rst = 1'b0;
        rand_cmd(0, 1'b1); rand_cmd(1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL sustained cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
            total++;
            if (o_w[0] !== logic'(i % 2)) begin
                bad++; $display("FAIL sustained_order step=%0d got winner=%0d want %0d", i, o_w[0], i % 2);
            end
            for (int n = 0; n < 2; n++) begin
                if (o_w[n] === 1'b0) cnt[n]++;
                wc[n] = (o_w[n] === 1'b1) ? wc[n] + 1 : 0;
                if (wc[n] > mx) mx = wc[n];
                if (!e_wait[n]) rand_cmd(n, 1'b1);
            end
        end
        total++;
        if (cnt[0] != 4 || cnt[1] != 4 || mx > 1) begin
            bad++; $display("FAIL sustained_fair got g0=%0d g1=%0d maxwait=%0d want 4 4 <=1", cnt[0], cnt[1], mx);
        end
        set_idle(0); set_idle(1);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL sustained_drain cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
        end
    endtask

    task automatic test_byte_write();
        set_cmd(1, 1'b0, 1'b1, 10'h3FF, 4'b0011, 32'hAABBCCDD); set_idle(0);
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL byte_write cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
            if (i == 2) begin
                total++;
                if (o_rv_a[0] !== 1'b1 || o_rd_a !== 32'h0000CCDD) begin
                    bad++; $display("FAIL byte_write_rl1 got v=%b d=%h want 1 0000ccdd", o_rv_a[0], o_rd_a);
                end
            end
            if (i == 3) begin
                total++;
                if (o_rv_b[0] !== 1'b1 || o_rd_b !== 32'h0000CCDD) begin
                    bad++; $display("FAIL byte_write_rl2 got v=%b d=%h want 1 0000ccdd", o_rv_b[0], o_rd_b);
                end
            end
            set_idle(1);
            if (i == 0) set_cmd(0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0); else set_idle(0);
        end
    endtask

    task automatic test_reset_mid_read();
        set_cmd(0, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0); set_idle(1);
        step();
        set_idle(0); s_rst = 1'b1;
        step();
        total++;
        if (o_rv_a[0] !== 1'b0 || o_rv_b[0] !== 1'b0) begin
            bad++; $display("FAIL reset_mid_read got v_rl1=%b v_rl2=%b want 0 0", o_rv_a[0], o_rv_b[0]);
        end
        s_rst = 1'b0;
        step();
        total++;
        if (o_rv_b[0] !== 1'b0 || o_rv_a[0] !== 1'b0) begin
            bad++; $display("FAIL reset_mid_read_late got v_rl1=%b v_rl2=%b want 0 0", o_rv_a[0], o_rv_b[0]);
        end
        set_cmd(0, 1'b1, 1'b0, 10'h001, 4'hF, 32'h0);
        set_cmd(1, 1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
        step();
        total++;
        if (o_w[0] !== 1'b0 || o_w[1] !== 1'b1) begin
            bad++; $display("FAIL reset_first_contention got w0=%b w1=%b want 0 1", o_w[0], o_w[1]);
        end
        set_idle(0);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL reset_recover cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
            set_idle(1);
        end
    endtask

    task automatic test_rl2();
        int cnt [2];
        cnt[0] = 0; cnt[1] = 0;
        for (int i = 0; i < 14; i++) begin
            set_idle(0); set_idle(1);
            if (i < 12) set_cmd(i % 2, 1'b1, 1'b0, 10'(i % 16), 4'hF, 32'h0);
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL rl2_alternate cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
            if (i >= 2) begin
                if (o_rv_b[0] === 1'b1) cnt[0]++;
                if (o_rv_b[1] === 1'b1) cnt[1]++;
            end
        end
        total++;
        if (cnt[0] != 6 || cnt[1] != 6) begin
            bad++; $display("FAIL rl2_count got v0=%0d v1=%0d want 6 6", cnt[0], cnt[1]);
        end
    endtask

    task automatic test_random();
        rand_cmd(0, 1'b0); rand_cmd(1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step();
            total++;
            if (obs_all !== exp_all) begin
                bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc - 1, obs_all, exp_all);
            end
            for (int n = 0; n < 2; n++) if (!e_wait[n]) rand_cmd(n, 1'b0);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; m_last = 1'b1; s_rst = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0; mem_b[i] = 32'h0; m_mem[i] = 32'h0;
        end
        set_idle(0); set_idle(1);
        @(posedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_sustained();
        test_byte_write();
        test_reset_mid_read();
        test_rl2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
